// File: rtl/eq_seq_defs.sv
// rtl/eq_seq_defs.sv - shared state encodings and slice width for the sequenced equality controller
package eq_seq_defs;

    localparam int SLICE_W = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/eq2_slice.sv
// rtl/eq2_slice.sv - combinational 2-bit equality slice, the shared comparator resource
module eq2_slice (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic       z
);

    assign z = (x == y);

endmodule

// File: rtl/eq_seq_ctrl.sv
// rtl/eq_seq_ctrl.sv - sequenced equality controller, 2 bits per clock; EQ_SEQ_EARLY_EXIT_EN stops at first mismatch
module eq_seq_ctrl
    import eq_seq_defs::*;
#(
    parameter  int WIDTH  = 8,
    localparam int SLICES = WIDTH / 2,
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic [IDX_W-1:0] mismatch_idx
);

`ifdef EQ_SEQ_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    state_t           state, state_n;
    logic [WIDTH-1:0] sa, sa_n;
    logic [WIDTH-1:0] sb, sb_n;
    logic [IDX_W-1:0] cnt, cnt_n;
    logic             eq_acc, eq_acc_n;
    logic             eq_q, eq_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic             s_eq;
    logic             last_slice;

    eq2_slice u_slice (
        .x (sa[SLICE_W-1:0]),
        .y (sb[SLICE_W-1:0]),
        .z (s_eq)
    );

    assign last_slice = (cnt == IDX_W'(SLICES - 1));

    always_comb begin
        state_n  = state;
        sa_n     = sa;
        sb_n     = sb;
        cnt_n    = cnt;
        eq_acc_n = eq_acc;
        eq_n     = eq_q;
        idx_n    = idx_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    sa_n     = a;
                    sb_n     = b;
                    cnt_n    = '0;
                    eq_acc_n = 1'b1;
                    eq_n     = 1'b0;
                    idx_n    = '0;
                    state_n  = S_RUN;
                end
            end
            S_RUN: begin
                // Only the lowest mismatching slice is recorded.
                if (!s_eq && eq_acc) begin
                    idx_n    = cnt;
                    eq_acc_n = 1'b0;
                end
                sa_n  = sa >> SLICE_W;
                sb_n  = sb >> SLICE_W;
                cnt_n = cnt + IDX_W'(1);
                if (last_slice || (EARLY_EXIT && !s_eq)) begin
                    // Fold in the current slice so eq is already final in DONE.
                    eq_n    = eq_acc & s_eq;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            sa     <= '0;
            sb     <= '0;
            cnt    <= '0;
            eq_acc <= 1'b0;
            eq_q   <= 1'b0;
            idx_q  <= '0;
        end else begin
            state  <= state_n;
            sa     <= sa_n;
            sb     <= sb_n;
            cnt    <= cnt_n;
            eq_acc <= eq_acc_n;
            eq_q   <= eq_n;
            idx_q  <= idx_n;
        end
    end

    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);
    assign eq           = eq_q;
    assign mismatch_idx = idx_q;

endmodule
